// File: rtl/btn_conditioner.sv
// Button front end: two-flop synchronizer, per-bit debounce counter and
// rising-edge detect with lowest-index-wins arbitration into a one-hot load strobe.
module btn_conditioner #(
   parameter int NBTN      = 3,
   parameter int DB_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            btn_Reset,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] pulsador,
   output logic [NBTN-1:0] btn_level
);

   localparam int CNT_W = $clog2(DB_CYCLES);

   logic [NBTN-1:0]  sync1_q;
   logic [NBTN-1:0]  sync2_q;
   logic [NBTN-1:0]  stable_q;
   logic [NBTN-1:0]  stable_d;
   logic [NBTN-1:0]  stableDly_q;
   logic [NBTN-1:0]  pulse_q;
   logic [NBTN-1:0]  pulse_d;
   logic [NBTN-1:0]  rise;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [CNT_W-1:0] cnt_d [NBTN];

   // A counter only runs while the synchronized input disagrees with the
   // accepted level; any agreement throws the partial count away.
   always_comb begin
      for (int i = 0; i < NBTN; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // x & -x isolates the lowest set bit, so simultaneous presses collapse
   // to the lowest-index button and the rest are dropped.
   always_comb begin
      rise    = stable_q & ~stableDly_q;
      pulse_d = rise & (~rise + NBTN'(1));
   end

   always_ff @(posedge clk or negedge btn_Reset) begin
      if (!btn_Reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         stableDly_q <= '0;
         pulse_q     <= '0;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q     <= btn_raw;
         sync2_q     <= sync1_q;
         stable_q    <= stable_d;
         stableDly_q <= stable_q;
         pulse_q     <= pulse_d;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign pulsador  = pulse_q;
   assign btn_level = stable_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DB_CYCLES=4): expected strobes are
// queued with their edge number as stimulus is applied and matched by a monitor.
module tb_btn_conditioner;

   localparam int NBTN = 3;
   localparam int DBC  = 4;

   logic            clk;
   logic            btn_Reset;
   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] pulsador;
   logic [NBTN-1:0] btn_level;

   typedef struct {
      int              edgeNum;
      logic [NBTN-1:0] val;
   } expT;

   expT sbQ[$];
   int  edgeCount = 0;
   int  total     = 0;
   int  bad       = 0;

   btn_conditioner #(.NBTN(NBTN), .DB_CYCLES(DBC)) dut (
      .clk       (clk),
      .btn_Reset (btn_Reset),
      .btn_raw   (btn_raw),
      .pulsador  (pulsador),
      .btn_level (btn_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edgeCount++;

   // Scoreboard monitor: every strobe must match the head of the queue in both
   // value and edge; an expected strobe whose edge has passed is reported missing.
   always @(negedge clk) begin
      expT f;
      if (pulsador !== '0) begin
         total++;
         if (sbQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_pulse: got %b at edge %0d, wanted none", pulsador, edgeCount);
         end else begin
            f = sbQ.pop_front();
            if (pulsador !== f.val || edgeCount != f.edgeNum) begin
               bad++;
               $display("[TB] FAIL pulse: got %b at edge %0d, wanted %b at edge %0d",
                        pulsador, edgeCount, f.val, f.edgeNum);
            end
         end
      end else if (sbQ.size() != 0 && edgeCount >= sbQ[0].edgeNum) begin
         f = sbQ.pop_front();
         total++;
         bad++;
         $display("[TB] FAIL missing_pulse: got 000 at edge %0d, wanted %b at edge %0d",
                  edgeCount, f.val, f.edgeNum);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input int edgeNum, input logic [NBTN-1:0] val);
      expT e;
      e.edgeNum = edgeNum;
      e.val     = val;
      sbQ.push_back(e);
   endtask

   task automatic test_reset();
      btn_Reset = 1'b0;
      btn_raw   = '0;
      repeat (3) step();
      total++;
      if (pulsador !== '0) begin
         bad++;
         $display("[TB] FAIL reset_pulsador: got %b, wanted 000", pulsador);
      end
      total++;
      if (btn_level !== '0) begin
         bad++;
         $display("[TB] FAIL reset_level: got %b, wanted 000", btn_level);
      end
      btn_Reset = 1'b1;
      step();
      btn_raw = 3'b111;
      pushExp(edgeCount + DBC + 3, 3'b001);
      repeat (10) step();
      total++;
      if (btn_level !== 3'b111) begin
         bad++;
         $display("[TB] FAIL all_held_level: got %b, wanted 111", btn_level);
      end
      #3;
      btn_Reset = 1'b0;
      #1;
      total++;
      if (pulsador !== '0) begin
         bad++;
         $display("[TB] FAIL async_reset_pulsador: got %b, wanted 000", pulsador);
      end
      total++;
      if (btn_level !== '0) begin
         bad++;
         $display("[TB] FAIL async_reset_level: got %b, wanted 000", btn_level);
      end
      btn_raw = '0;
      repeat (2) step();
      btn_Reset = 1'b1;
      repeat (3) step();
   endtask

   task automatic test_clean_press();
      btn_raw = 3'b010;
      pushExp(edgeCount + DBC + 3, 3'b010);
      repeat (DBC + 1) step();
      total++;
      if (btn_level !== 3'b000) begin
         bad++;
         $display("[TB] FAIL press_level_early: got %b, wanted 000", btn_level);
      end
      step();
      total++;
      if (btn_level !== 3'b010) begin
         bad++;
         $display("[TB] FAIL press_level: got %b, wanted 010", btn_level);
      end
      repeat (14) step();
      btn_raw = 3'b000;
      repeat (DBC + 1) step();
      total++;
      if (btn_level !== 3'b010) begin
         bad++;
         $display("[TB] FAIL release_level_early: got %b, wanted 010", btn_level);
      end
      step();
      total++;
      if (btn_level !== 3'b000) begin
         bad++;
         $display("[TB] FAIL release_level: got %b, wanted 000", btn_level);
      end
      repeat (6) step();
   endtask

   task automatic test_bounce();
      logic [4:0] pattern;
      pattern = 5'b10101;
      for (int k = 0; k < 5; k++) begin
         btn_raw = {2'b00, pattern[k]};
         if (k < 4) repeat (2) step();
      end
      pushExp(edgeCount + DBC + 3, 3'b001);
      repeat (12) step();
      total++;
      if (btn_level !== 3'b001) begin
         bad++;
         $display("[TB] FAIL bounce_level: got %b, wanted 001", btn_level);
      end
      btn_raw = 3'b000;
      repeat (8) step();
   endtask

   task automatic test_simultaneous();
      btn_raw = 3'b110;
      pushExp(edgeCount + DBC + 3, 3'b010);
      repeat (DBC + 2) step();
      total++;
      if (btn_level !== 3'b110) begin
         bad++;
         $display("[TB] FAIL simul_level: got %b, wanted 110", btn_level);
      end
      repeat (4) step();
      btn_raw = 3'b000;
      repeat (8) step();
   endtask

   task automatic test_independent();
      btn_raw = 3'b100;
      pushExp(edgeCount + DBC + 3, 3'b100);
      repeat (10) step();
      btn_raw = 3'b101;
      pushExp(edgeCount + DBC + 3, 3'b001);
      repeat (10) step();
      total++;
      if (btn_level !== 3'b101) begin
         bad++;
         $display("[TB] FAIL indep_level: got %b, wanted 101", btn_level);
      end
      btn_raw = 3'b000;
      repeat (8) step();
   endtask

   task automatic test_reset_midcount();
      btn_raw = 3'b100;
      repeat (3) step();
      btn_Reset = 1'b0;
      step();
      total++;
      if (btn_level !== 3'b000 || pulsador !== 3'b000) begin
         bad++;
         $display("[TB] FAIL midcount_reset: got level %b pulse %b, wanted 000 000", btn_level, pulsador);
      end
      btn_Reset = 1'b1;
      pushExp(edgeCount + DBC + 3, 3'b100);
      repeat (10) step();
      total++;
      if (btn_level !== 3'b100) begin
         bad++;
         $display("[TB] FAIL midcount_level: got %b, wanted 100", btn_level);
      end
      btn_raw = 3'b000;
      repeat (8) step();
   endtask

   initial begin
      btn_Reset = 1'b0;
      btn_raw   = '0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_independent();
      test_reset_midcount();
      step();
      total++;
      if (sbQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL leftover_expected: got %0d pending, wanted 0", sbQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage for the push-buttons that drive the calculator's operand/opcode load bus. It synchronizes the raw asynchronous button inputs to `clk`, debounces each one independently, and turns every accepted press into a single-cycle, one-hot strobe. The strobe bus connects directly to the 3-bit load-select input (`pulsador`) of the operand-load/ALU stage downstream. The block also exports the debounced button levels.

## Interface
- `NBTN`, 3: number of buttons. Bit 0 = load A, bit 1 = load B, bit 2 = load opcode.
- `DB_CYCLES`, 1000000: number of consecutive stable synchronized samples required to accept a level change. Minimum 2. Benches use 4.
- `CNT_W`, `$clog2(DB_CYCLES)`: width of each debounce counter. Derived, never overridden.
- `clk`  in  1  single system clock; all state is on its rising edge.
- `btn_Reset`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  NBTN  raw button levels, asynchronous to `clk`, active-high.
- `pulsador`  out  NBTN  one-hot load strobe; at most one bit high, for exactly one cycle per accepted press.
- `btn_level`  out  NBTN  debounced button levels.

## Operation
- **Synchronizer:** two flops per bit, `btn_raw` → `s1` → `s2`, both cleared by reset. `s2` is the only signal the logic below uses.
- **Debounce, per bit i:** registers `stable[i]` and `cnt[i]`. On each clock edge:
  - if `s2[i] == stable[i]`: `cnt[i] <= 0`.
  - else if `cnt[i] == DB_CYCLES-1`: `stable[i] <= s2[i]`, `cnt[i] <= 0`.
  - else: `cnt[i] <= cnt[i] + 1`.
- Any disagreement shorter than `DB_CYCLES` samples is discarded, and its counter restarts from 0 at the next disagreement.
- `btn_level = stable`, driven straight from the registers.
- **Rise detect:** keep `stable_d` as a one-cycle-delayed copy of `stable`. `rise = stable & ~stable_d`.
- **Arbitration:** if several bits of `rise` are set in the same cycle, the lowest index wins and the others are dropped (not queued). No pulse is produced on release (falling edge).
- **Output:** `pulsador` is a register loaded each cycle with the one-hot arbitrated `rise`, or 0 when there is none.
- **Hold:** holding a button produces exactly one pulse; no auto-repeat. A new pulse requires a debounced release followed by a debounced press.
- **Independence:** bits are fully independent. A held button does not block pulses from the others.

## Timing
- Reset (asynchronous assert, synchronous use after deassert) clears `s1`, `s2`, `stable`, `stable_d`, all `cnt`, and `pulsador`.
- Reset values of the outputs: `pulsador = 0`, `btn_level = 0`.
- **Press latency:** raw rises before edge 1 → `s2` high after edge 2 → `stable` high after edge `DB_CYCLES+2` → `pulsador` high after edge `DB_CYCLES+3`, for exactly one cycle.
  - `btn_level` rises one cycle earlier than `pulsador`.
- **Release latency:** `btn_level` falls after edge `DB_CYCLES+2`; no strobe.
- **Bounce:** a toggle sequence whose every interval is shorter than `DB_CYCLES` cycles produces no level change and no pulse. Acceptance happens `DB_CYCLES` cycles after the last toggle.
- **Reset mid-count:** the counter, stable level, and any pending pulse are lost.
  - A button still held after reset deasserts is treated as a new press and produces one pulse at edge `DB_CYCLES+3` after deassertion.
- **Counter bound:** the counter never exceeds `DB_CYCLES-1`. No wrap-around can occur.
- Outputs are registered, so the downstream stage samples them on the same clock with no further synchronization.

## Test plan
All scenarios use `DB_CYCLES=4`, `NBTN=3`.

1. **Reset:** `btn_Reset=0` with `btn_raw=3'b111` → `pulsador=0` and `btn_level=0` immediately, without waiting for a clock edge.
2. **Clean press/release:** `btn_raw[1]` rises and is held 20 cycles, then released → `btn_level=3'b010` after edge 6; `pulsador=3'b010` after edge 7 for exactly one cycle; `btn_level` returns to 0 six edges after release; no second pulse.
3. **Bounce:** `btn_raw[0]` toggles 1,0,1,0,1 with 2-cycle intervals, then stays high → no pulse during the bounce; exactly one `3'b001` pulse 7 edges after the final rise.
4. **Simultaneous press:** `btn_raw` goes `000` → `110` in one cycle → a single `pulsador=3'b010` pulse; bit 2 never pulses; `btn_level=3'b110`.
5. **Independent buttons:** bit 2 held; bit 0 pressed 10 cycles later → first pulse `3'b100`, then `3'b001`; the two pulses never overlap.
6. **Reset mid-count:** `btn_raw[2]` rises; reset is asserted for 1 cycle at edge 4 while the button stays held → no pulse before reset; one `3'b100` pulse 7 edges after reset deasserts.
